rr_mux3_feeder: RTL and testbench

- Registered 3-source round-robin arbiter for a single-bit-wide stream (DATA_W = 1 default).
- Sits directly upstream of mux3to1.
- Drives the 2-bit select that mux3to1 consumes: values 0/1/2 only, 3 never produced.
- Also registers the winning source's data into a one-entry valid/ready output stage, so the downstream consumer sees sel and data stable together.

---
 rtl/rr_mux3_feeder_if.sv | 27 ++
 rtl/rr_mux3_feeder.sv | 110 +++++++++++
 tb/tb_rr_mux3_feeder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux3_feeder_if.sv
// Handshake bundle between three request sources, the round-robin feeder and
// its downstream consumer (mux3to1 select plus registered data word).
interface rr_mux3_feeder_if #(
   parameter int DATA_W = 1,
   parameter int CNT_W  = 16
);
   logic [2:0]        in_valid;
   logic [2:0]        in_ready;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] c;
   logic [1:0]        sel;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  xfer_cnt;

   modport slave (
      input  in_valid, a, b, c, out_ready,
      output in_ready, sel, out_valid, out_data, xfer_cnt
   );

   modport master (
      output in_valid, a, b, c, out_ready,
      input  in_ready, sel, out_valid, out_data, xfer_cnt
   );
endinterface

// File: rtl/rr_mux3_feeder.sv
// Three-source round-robin arbiter feeding a one-entry registered output stage
// whose sel/out_data pair drives a downstream mux3to1.
//
// state | meaning
// EMPTY | output register holds no word, out_valid = 0
// FULL  | output register holds a word, out_valid = 1
module rr_mux3_feeder #(
   parameter int DATA_W = 1,
   parameter int CNT_W  = 16
) (
   input logic             clk,
   input logic             rst,
   rr_mux3_feeder_if.slave bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [1:0]        last_gnt_q;
   logic [1:0]        sel_q;
   logic [DATA_W-1:0] data_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              can_load;
   logic              any_req;
   logic              found;
   logic [1:0]        winner;
   logic [1:0]        cand [3];
   logic [2:0]        ready_vec;
   logic              accept;
   logic              handshake;
   logic [DATA_W-1:0] win_data;

   function automatic logic [1:0] next_src(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   // Search order starts just after the last granted source and ends on it.
   always_comb begin
      cand[0] = next_src(last_gnt_q);
      cand[1] = next_src(next_src(last_gnt_q));
      cand[2] = last_gnt_q;
      found   = 1'b0;
      winner  = 2'd0;
      for (int k = 0; k < 3; k++) begin
         if (!found && bus.in_valid[cand[k]]) begin
            found  = 1'b1;
            winner = cand[k];
         end
      end
   end

   always_comb begin
      win_data = bus.a;
      case (winner)
         2'd1:    win_data = bus.b;
         2'd2:    win_data = bus.c;
         default: win_data = bus.a;
      endcase
   end

   assign any_req   = |bus.in_valid;
   assign can_load  = (state_q == EMPTY) || bus.out_ready;
   assign ready_vec = (can_load && any_req && found && !rst) ? (3'b001 << winner) : 3'b000;
   assign accept    = |ready_vec;
   assign handshake = (state_q == FULL) && bus.out_ready && !rst;

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (accept) state_d = FULL;
         end
         FULL: begin
            if (accept)         state_d = FULL;
            else if (handshake) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         last_gnt_q <= 2'd2;
         sel_q      <= 2'd0;
         data_q     <= '0;
         cnt_q      <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            sel_q      <= winner;
            data_q     <= win_data;
            last_gnt_q <= winner;
         end
         if (handshake) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.in_ready  = ready_vec;
   assign bus.sel       = sel_q;
   assign bus.out_valid = (state_q == FULL);
   assign bus.out_data  = data_q;
   assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_mux3_feeder.sv
// Directed and random stimulus for rr_mux3_feeder, checked every cycle against
// a queue-based arbitration model plus literal expectations.
module tb_rr_mux3_feeder;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   rr_mux3_feeder_if #(.DATA_W(1), .CNT_W(16)) bus ();

   rr_mux3_feeder #(.DATA_W(1), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int src;
      int data;
   } ent_t;

   ent_t        q[$];
   int          m_last = 2;
   int          m_sel  = 0;
   logic [15:0] m_cnt  = '0;

   // Model: check what the DUT shows now, then advance to the next edge.
   always @(negedge clk) begin
      int   w;
      bit   got;
      bit   can;
      bit   hs;
      int   exp_ready;
      int   src_data [3];
      ent_t e;
      src_data[0] = int'(bus.a);
      src_data[1] = int'(bus.b);
      src_data[2] = int'(bus.c);
      got = 1'b0;
      w   = 0;
      for (int k = 1; k <= 3; k++) begin
         if (!got && bus.in_valid[(m_last + k) % 3]) begin
            got = 1'b1;
            w   = (m_last + k) % 3;
         end
      end
      can = (q.size() == 0) || bus.out_ready;
      exp_ready = (!rst && can && got) ? (1 << w) : 0;

      chk("m_in_ready", int'(bus.in_ready), exp_ready);
      chk("m_out_valid", int'(bus.out_valid), (q.size() != 0) ? 1 : 0);
      chk("m_sel_not3", (bus.sel == 2'd3) ? 1 : 0, 0);
      chk("m_xfer_cnt", int'(bus.xfer_cnt), int'(m_cnt));
      if (q.size() != 0) begin
         chk("m_sel", int'(bus.sel), q[0].src);
         chk("m_out_data", int'(bus.out_data), q[0].data);
      end else begin
         chk("m_sel_idle", int'(bus.sel), m_sel);
      end

      if (rst) begin
         q.delete();
         m_cnt  = '0;
         m_last = 2;
         m_sel  = 0;
      end else begin
         hs = (q.size() != 0) && bus.out_ready;
         if (hs) begin
            void'(q.pop_front());
            m_cnt = m_cnt + 16'd1;
         end
         if (can && got) begin
            e.src  = w;
            e.data = src_data[w];
            q.push_back(e);
            m_last = w;
            m_sel  = w;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rr_data [6];
      rr_data = '{1, 0, 1, 1, 0, 1};
      rst           = 1'b1;
      bus.in_valid  = 3'b111;
      bus.a         = 1'b0;
      bus.b         = 1'b0;
      bus.c         = 1'b0;
      bus.out_ready = 1'b0;

      // reset held with all sources requesting
      repeat (3) begin
         step();
         chk("rst_in_ready", int'(bus.in_ready), 0);
         chk("rst_out_valid", int'(bus.out_valid), 0);
         chk("rst_sel", int'(bus.sel), 0);
         chk("rst_cnt", int'(bus.xfer_cnt), 0);
      end
      rst = 1'b0;
      #1;
      chk("rel_in_ready", int'(bus.in_ready), 1);

      // round robin, full throughput
      bus.a = 1'b1; bus.b = 1'b0; bus.c = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rr_sel", int'(bus.sel), i % 3);
         chk("rr_data", int'(bus.out_data), rr_data[i]);
         chk("rr_valid", int'(bus.out_valid), 1);
      end
      bus.in_valid = 3'b000;
      step();
      chk("rr_cnt", int'(bus.xfer_cnt), 6);
      chk("rr_drain_valid", int'(bus.out_valid), 0);
      chk("rr_drain_sel", int'(bus.sel), 2);

      // back-pressure
      bus.in_valid = 3'b010; bus.b = 1'b1; bus.c = 1'b0; bus.out_ready = 1'b0;
      step();
      bus.in_valid = 3'b101;
      repeat (4) begin
         #1;
         chk("bp_in_ready", int'(bus.in_ready), 0);
         chk("bp_sel", int'(bus.sel), 1);
         chk("bp_data", int'(bus.out_data), 1);
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", int'(bus.in_ready), 4);
      step();
      chk("bp_sel_c", int'(bus.sel), 2);
      chk("bp_data_c", int'(bus.out_data), 0);
      step();
      chk("bp_sel_a", int'(bus.sel), 0);
      bus.in_valid = 3'b000;
      step();
      chk("bp_cnt", int'(bus.xfer_cnt), 9);

      // single requester
      bus.in_valid = 3'b010;
      #1;
      chk("single_ready0", int'(bus.in_ready), 2);
      repeat (3) begin
         step();
         chk("single_sel", int'(bus.sel), 1);
         chk("single_ready", int'(bus.in_ready), 2);
      end
      bus.in_valid = 3'b000;
      step();

      // reset while FULL and stalled
      bus.in_valid = 3'b100; bus.out_ready = 1'b0;
      step();
      chk("mid_sel2", int'(bus.sel), 2);
      chk("mid_full", int'(bus.out_valid), 1);
      rst = 1'b1; bus.in_valid = 3'b111;
      step();
      chk("mid_rst_valid", int'(bus.out_valid), 0);
      chk("mid_rst_sel", int'(bus.sel), 0);
      chk("mid_rst_cnt", int'(bus.xfer_cnt), 0);
      chk("mid_rst_ready", int'(bus.in_ready), 0);
      rst = 1'b0;
      #1;
      chk("mid_rel_ready", int'(bus.in_ready), 1);
      step();
      chk("mid_grant0", int'(bus.sel), 0);

      // random traffic checked by the model every cycle
      for (int i = 0; i < 1000; i++) begin
         bus.in_valid  = 3'($urandom_range(0, 7));
         bus.a         = 1'($urandom_range(0, 1));
         bus.b         = 1'($urandom_range(0, 1));
         bus.c         = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      bus.in_valid  = 3'b000;
      bus.out_ready = 1'b1;
      repeat (3) step();
      chk("final_empty", int'(bus.out_valid), 0);
      chk("final_cnt", int'(bus.xfer_cnt), int'(m_cnt));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
